demux_rr_scheduler: RTL
=======================

DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 Parameter START_CH, default 0, meaning: channel index (0..7) the pointer loads on reset and on frame restart.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream serial bit present.
REQ-005 in_data  input  1  serial data bit.
REQ-006 in_ready  output  1  block can accept in_data this cycle.
REQ-007 ch_mask  input  8  per-channel enable, bit i = channel i; present only with DEMUX_RR_MASK_EN.
REQ-008 d  output  1  data bit to the 1-to-8 demux.
REQ-009 sel  output  3  channel select to the 1-to-8 demux.
REQ-010 out_valid  output  1  d/sel carry a transfer this cycle.
REQ-011 frame_done  output  1  one-cycle pulse, coincident with the last enabled channel's transfer.

Function
REQ-012 Transfer occurs on a cycle where in_valid and in_ready are both 1; no other cycle changes the channel pointer.
REQ-013 Latency exactly 1 cycle: the cycle after a transfer, out_valid=1, d=accepted bit, sel=pointer value at accept time.
REQ-014 No transfer in the previous cycle -> out_valid=0 and d=0 (all demux outputs low); sel holds its last value.
REQ-015 After a transfer the pointer advances to the next enabled channel above the current one, wrapping 7->0; search is combinational over 8 channels.
REQ-016 frame_done=1 alongside out_valid when the served channel is the highest-index enabled channel (next pointer wraps); otherwise 0.
REQ-017 States: IDLE (no transfer since reset or last frame_done), RUN (mid-frame), STALL (mask all zero).
REQ-018 IDLE->RUN on a transfer not ending the frame; RUN->IDLE on a transfer ending the frame; any state->STALL when ch_mask==0; STALL->IDLE when ch_mask!=0.
REQ-019 in_ready=1 in IDLE and RUN, 0 in STALL; in_ready is independent of in_valid.
REQ-020 If the pointer's channel is disabled at accept time, the accepted bit goes to the next enabled channel at or above the pointer (wrapping); frame_done evaluates against that channel.
REQ-021 Single enabled channel: every transfer targets that channel and pulses frame_done.
REQ-022 Mask changes take effect on the next transfer; an in-flight output (already registered) is not modified.

Reset
REQ-023 While rst=1: d=0, sel=START_CH, out_valid=0, frame_done=0, pointer=START_CH, state=IDLE; in_ready follows REQ-019 from IDLE/STALL.
REQ-024 Reset asserted mid-frame discards frame progress; first transfer after release targets START_CH (or next enabled above it).

Configuration
REQ-025 Macro DEMUX_RR_MASK_EN defined: ch_mask port exists and REQ-015..REQ-022 use it.
REQ-026 Macro undefined: ch_mask port absent, mask fixed 8'hFF, STALL unreachable, strict 0..7 round robin from START_CH, frame_done on channel 7.

Structure
REQ-027 Package demux_pkg holds NUM_CH=8, SEL_W=3, and the state enum type (IDLE, RUN, STALL).
REQ-028 Sub-module demux_rr_next: combinational, inputs pointer and mask, outputs target channel, next pointer, and wrap flag.
REQ-029 All outputs except in_ready are registered.

Verification
REQ-030 Full mask, 8 back-to-back transfers of in_data=1 from reset -> sel 0,1,...,7 on consecutive cycles, out_valid=1, frame_done only with sel=7.
REQ-031 ch_mask=8'b1010_0101, 5 transfers -> sel 0,2,5,7,0; frame_done with sel=7 only.
REQ-032 ch_mask=8'h00 with in_valid=1 -> in_ready=0, out_valid stays 0; set ch_mask=8'h10 -> next transfer gives sel=4, frame_done=1.
REQ-033 in_valid pattern 1,0,0,1 with in_data 1,x,x,0 -> outputs (sel 0,d 1), two idle cycles with d=0 and sel=0, then (sel 1,d 0).
REQ-034 Assert rst after transfer to sel=3, release -> outputs cleared immediately; next transfer gives sel=START_CH.
REQ-035 Build without DEMUX_RR_MASK_EN, START_CH=5 -> transfers give sel 5,6,7,0; frame_done with sel=7.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and the circular first-enabled search used by demux_rr_scheduler.
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    // Lowest channel at or above start (wrapping) whose mask bit is set; returns start if none.
    function automatic logic [SEL_W-1:0] first_enabled(
        input logic [NUM_CH-1:0] mask,
        input logic [SEL_W-1:0]  start
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        first_enabled = start;
        found         = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = start + SEL_W'(i);
            if (!found && mask[idx]) begin
                first_enabled = idx;
                found         = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/demux_rr_next.sv
// Combinational round-robin step: channel served from the current pointer, the pointer after it,
// and whether that channel closes the frame (it is the highest enabled one).
module demux_rr_next
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]  ptr_i,
    input  logic [NUM_CH-1:0] mask_i,
    output logic [SEL_W-1:0]  target_o,
    output logic [SEL_W-1:0]  next_ptr_o,
    output logic              wrap_o
);

    assign target_o   = first_enabled(mask_i, ptr_i);
    assign next_ptr_o = first_enabled(mask_i, target_o + SEL_W'(1));
    // Not moving upward means no enabled channel lies above the target; covers the single-channel case too.
    assign wrap_o     = (next_ptr_o <= target_o);

endmodule

// File: rtl/demux_rr_scheduler.sv
// Serial-to-demux round-robin scheduler: each accepted bit is registered onto d/sel one cycle later.
// Optional per-channel enable port ch_mask is built only when DEMUX_RR_MASK_EN is defined.
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter int unsigned START_CH = 0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_data,
    output logic              in_ready,
`ifdef DEMUX_RR_MASK_EN
    input  logic [NUM_CH-1:0] ch_mask,
`endif
    output logic              d,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic              frame_done
);

    localparam logic [SEL_W-1:0] START_SEL = SEL_W'(START_CH);

    logic [NUM_CH-1:0] mask;
`ifdef DEMUX_RR_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] sel_q;
    logic             d_q, out_valid_q, frame_done_q;

    logic [SEL_W-1:0] target, next_ptr;
    logic             wrap, mask_any, transfer;

    demux_rr_next u_next (
        .ptr_i      (ptr_q),
        .mask_i     (mask),
        .target_o   (target),
        .next_ptr_o (next_ptr),
        .wrap_o     (wrap)
    );

    assign mask_any = |mask;
    // An all-zero mask has no target, so it must also block acceptance in the cycle before STALL is entered.
    assign in_ready = (state_q != STALL) && mask_any;
    assign transfer = in_valid && in_ready;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (!mask_any) begin
            state_d = STALL;
        end else begin
            unique case (state_q)
                IDLE:    if (transfer) state_d = wrap ? IDLE : RUN;
                RUN:     if (transfer && wrap) state_d = IDLE;
                STALL:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= START_SEL;
            sel_q        <= START_SEL;
            d_q          <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (transfer) begin
            ptr_q        <= next_ptr;
            sel_q        <= target;
            d_q          <= in_data;
            out_valid_q  <= 1'b1;
            frame_done_q <= wrap;
        end else begin
            // sel holds so the demux select does not toggle between transfers.
            d_q          <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end
    end

    assign d          = d_q;
    assign sel        = sel_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule
